// File: rtl/qe_pkg.sv
// Shared constants for the Sinclair QL expansion-bus to W5300 bus-cycle controller.
// Holds the FSM state encoding, the slot prefix and the sub-window offsets.
package qe_pkg;

    typedef logic [1:0] qe_state_t;

    localparam qe_state_t ST_IDLE     = 2'd0;
    localparam qe_state_t ST_STROBE   = 2'd1;
    localparam qe_state_t ST_ACK      = 2'd2;
    localparam qe_state_t ST_WAIT_END = 2'd3;

    localparam logic [1:0] SLOT_PREFIX = 2'b11;
    localparam logic [2:0] WIN_W5300   = 3'b111;
    localparam logic [3:0] WIN_CTRL    = 4'hC;

    // A19..A18 select the expansion area, A17..A14 must match the slot switches.
    function automatic logic card_sel(input logic [9:0] addr, input logic [3:0] slot);
        return (addr[9:8] == SLOT_PREFIX) && (addr[7:4] == slot);
    endfunction

endpackage

// File: rtl/qe_sync.sv
// Two-flop synchroniser for asynchronous bus control inputs.
// Width and per-bit reset value are parameters so idle-high strobes reset inactive.
module qe_sync #(
    parameter int unsigned         WIDTH     = 1,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rstl,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rstl) begin
        if (!i_rstl) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/qe_control.sv
// QL expansion-bus cycle controller for a W5300 Ethernet card: slot decode, W5300
// strobes, data-buffer control, DSMCL/DTACKL handshake and the W5300 reset pulse.
module qe_control
    import qe_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 7,
    parameter int unsigned RST_CYCLES    = 256
) (
    input  logic       clk,
    input  logic       rstl,
    input  logic [9:0] address,
    input  logic [3:0] sp,
    input  logic       asl,
    input  logic       dsl,
    input  logic       rdwl,
    output logic       dtackl,
    output logic       dsmcl,
    output logic       dbenl,
    output logic       dbdir,
    output logic       wizcsl,
    output logic       wizrdl,
    output logic       wizwrl,
    output logic       wizrstl
);

    localparam int unsigned SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [SCW-1:0] STROBE_LAST = SCW'(STROBE_CYCLES - 1);
    localparam logic [RCW-1:0] RST_LAST    = RCW'(RST_CYCLES - 1);

    logic [2:0] w_sync;
    logic       w_sasl;
    logic       w_sdsl;
    logic       w_srdwl;
    logic       w_card_sel;
    logic       w_wiz_win;
    logic       w_ctrl_win;

    qe_state_t      r_state;
    logic [SCW-1:0] r_scnt;
    logic           r_dtackl;
    logic           r_dbenl;
    logic           r_dbdir;
    logic           r_wizcsl;
    logic           r_wizrdl;
    logic           r_wizwrl;
    logic [RCW-1:0] r_rst_cnt;
    logic           r_wizrstl;

    qe_state_t      w_state_nxt;
    logic [SCW-1:0] w_scnt_nxt;
    logic           w_dtackl_nxt;
    logic           w_dbenl_nxt;
    logic           w_dbdir_nxt;
    logic           w_wizcsl_nxt;
    logic           w_wizrdl_nxt;
    logic           w_wizwrl_nxt;
    logic           w_ctrl_wr;

    qe_sync #(
        .WIDTH     (3),
        .RESET_VAL (3'b111)
    ) u_sync (
        .i_clk  (clk),
        .i_rstl (rstl),
        .i_d    ({asl, dsl, rdwl}),
        .o_q    (w_sync)
    );

    assign w_sasl  = w_sync[2];
    assign w_sdsl  = w_sync[1];
    assign w_srdwl = w_sync[0];

    assign w_card_sel = card_sel(address, sp);
    assign w_wiz_win  = w_card_sel && (address[3:1] == WIN_W5300);
    assign w_ctrl_win = w_card_sel && (address[3:0] == WIN_CTRL);

    // Live asl so the QL sees the claim within the address phase; rstl forces it inactive.
    assign dsmcl = ~(rstl & ~asl & (w_wiz_win | w_ctrl_win));

    always_comb begin
        w_state_nxt  = r_state;
        w_scnt_nxt   = r_scnt;
        w_dtackl_nxt = r_dtackl;
        w_dbenl_nxt  = r_dbenl;
        w_dbdir_nxt  = r_dbdir;
        w_wizcsl_nxt = r_wizcsl;
        w_wizrdl_nxt = r_wizrdl;
        w_wizwrl_nxt = r_wizwrl;
        w_ctrl_wr    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (!w_sasl && !w_sdsl) begin
                    if (w_wiz_win) begin
                        w_state_nxt  = ST_STROBE;
                        w_scnt_nxt   = '0;
                        w_wizcsl_nxt = 1'b0;
                        w_wizrdl_nxt = ~w_srdwl;
                        w_wizwrl_nxt = w_srdwl;
                        w_dbenl_nxt  = 1'b0;
                        w_dbdir_nxt  = w_srdwl;
                    end else if (w_ctrl_win) begin
                        w_state_nxt  = ST_ACK;
                        w_dtackl_nxt = 1'b0;
                        w_ctrl_wr    = ~w_srdwl;
                    end
                end
            end
            ST_STROBE: begin
                if (w_sasl) begin
                    // Master gave up before acknowledge: drop everything, never ack.
                    w_state_nxt  = ST_IDLE;
                    w_wizcsl_nxt = 1'b1;
                    w_wizrdl_nxt = 1'b1;
                    w_wizwrl_nxt = 1'b1;
                    w_dbenl_nxt  = 1'b1;
                    w_dbdir_nxt  = 1'b0;
                end else if (r_scnt == STROBE_LAST) begin
                    w_state_nxt  = ST_ACK;
                    w_dtackl_nxt = 1'b0;
                    w_wizwrl_nxt = 1'b1;
                end else begin
                    w_scnt_nxt = r_scnt + 1'b1;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_WAIT_END;
            end
            ST_WAIT_END: begin
                if (w_sasl && w_sdsl) begin
                    w_state_nxt  = ST_IDLE;
                    w_dtackl_nxt = 1'b1;
                    w_wizcsl_nxt = 1'b1;
                    w_wizrdl_nxt = 1'b1;
                    w_wizwrl_nxt = 1'b1;
                    w_dbenl_nxt  = 1'b1;
                    w_dbdir_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_dtackl_nxt = 1'b1;
                w_wizcsl_nxt = 1'b1;
                w_wizrdl_nxt = 1'b1;
                w_wizwrl_nxt = 1'b1;
                w_dbenl_nxt  = 1'b1;
                w_dbdir_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            r_state  <= ST_IDLE;
            r_scnt   <= '0;
            r_dtackl <= 1'b1;
            r_dbenl  <= 1'b1;
            r_dbdir  <= 1'b0;
            r_wizcsl <= 1'b1;
            r_wizrdl <= 1'b1;
            r_wizwrl <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_scnt   <= w_scnt_nxt;
            r_dtackl <= w_dtackl_nxt;
            r_dbenl  <= w_dbenl_nxt;
            r_dbdir  <= w_dbdir_nxt;
            r_wizcsl <= w_wizcsl_nxt;
            r_wizrdl <= w_wizrdl_nxt;
            r_wizwrl <= w_wizwrl_nxt;
        end
    end

    // Pulse runs from reset release and restarts on every control-window write.
    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            r_rst_cnt <= '0;
            r_wizrstl <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_rst_cnt <= '0;
            r_wizrstl <= 1'b0;
        end else if (!r_wizrstl) begin
            if (r_rst_cnt == RST_LAST) begin
                r_wizrstl <= 1'b1;
            end else begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end
        end
    end

    assign dtackl  = r_dtackl;
    assign dbenl   = r_dbenl;
    assign dbdir   = r_dbdir;
    assign wizcsl  = r_wizcsl;
    assign wizrdl  = r_wizrdl;
    assign wizwrl  = r_wizwrl;
    assign wizrstl = r_wizrstl;

endmodule

// File: tb/tb_qe_control.sv
// Self-checking bench for qe_control: vector table, hand sequences and random bus
// cycles checked every clock against a timeline model of the bus protocol.
module tb_qe_control;

    localparam int SC = 7;
    localparam int RC = 256;

    logic       clk = 1'b0;
    logic       rstl;
    logic [9:0] address;
    logic [3:0] sp;
    logic       asl;
    logic       dsl;
    logic       rdwl;
    logic       dtackl;
    logic       dsmcl;
    logic       dbenl;
    logic       dbdir;
    logic       wizcsl;
    logic       wizrdl;
    logic       wizwrl;
    logic       wizrstl;

    qe_control #(
        .STROBE_CYCLES (SC),
        .RST_CYCLES    (RC)
    ) u_dut (
        .clk     (clk),
        .rstl    (rstl),
        .address (address),
        .sp      (sp),
        .asl     (asl),
        .dsl     (dsl),
        .rdwl    (rdwl),
        .dtackl  (dtackl),
        .dsmcl   (dsmcl),
        .dbenl   (dbenl),
        .dbdir   (dbdir),
        .wizcsl  (wizcsl),
        .wizrdl  (wizrdl),
        .wizwrl  (wizwrl),
        .wizrstl (wizrstl)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int edge_n    = 0;
    int rst_start = 0;

    typedef struct {
        logic [9:0] addr;
        logic [3:0] slot;
        logic       rd;
        int         hold;
        logic [3:0] exp_seen; // {dsmcl, wizcsl, dtackl, dbenl} ever driven low
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b want %b", name, edge_n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    function automatic int decode(input logic [9:0] a, input logic [3:0] s);
        if (a[9:8] != 2'b11 || a[7:4] != s) return 0;
        if (a[3:1] == 3'b111) return 1;
        if (a[3:0] == 4'hC) return 2;
        return 0;
    endfunction

    function automatic logic rst_expect();
        return (edge_n - rst_start) >= RC;
    endfunction

    // Outputs k clocks after asl/dsl fall together, with both rising after clock h.
    // Bit order {dsmcl, dtackl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl}.
    function automatic logic [7:0] model(input int kind, input logic rd, input int h,
                                         input int k, input logic rst_hi);
        int   ack_k;
        int   end_k;
        logic abort;
        logic act;
        logic dt;
        logic wr_on;
        ack_k = 3 + SC;
        act   = 1'b0;
        dt    = 1'b0;
        wr_on = 1'b0;
        if (kind == 1) begin
            abort = (h + 3 <= ack_k);
            end_k = abort ? h + 3 : ((h + 3 > ack_k + 2) ? h + 3 : ack_k + 2);
            act   = (k >= 3) && (k < end_k);
            dt    = !abort && (k >= ack_k) && (k < end_k);
            wr_on = act && !rd && (abort || k < ack_k);
        end else if (kind == 2) begin
            end_k = (h + 3 > 5) ? h + 3 : 5;
            dt    = (k >= 3) && (k < end_k);
        end
        return {!(kind != 0 && k < h), !dt, !act, act && rd, !act, !(act && rd), !wr_on,
                rst_hi};
    endfunction

    task automatic run_cycle(input logic [9:0] a, input logic [3:0] s, input logic rd,
                             input int h, output logic [3:0] seen);
        int         kind;
        logic [7:0] got;
        kind    = decode(a, s);
        seen    = 4'b0;
        address = a;
        sp      = s;
        rdwl    = rd;
        asl     = 1'b0;
        dsl     = 1'b0;
        for (int k = 0; k <= h + SC + 7; k++) begin
            if (k == h) begin
                asl = 1'b1;
                dsl = 1'b1;
            end
            if (kind == 2 && !rd && k == 3) rst_start = edge_n;
            #1;
            got  = {dsmcl, dtackl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl};
            chk($sformatf("cycle a=%h rd=%b h=%0d k=%0d", a, rd, h, k), got,
                model(kind, rd, h, k, rst_expect()));
            seen = seen | {~dsmcl, ~wizcsl, ~dtackl, ~dbenl};
            tick();
        end
    endtask

    task automatic wait_chk(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("wizrstl pulse", 8'(wizrstl), 8'(rst_expect()));
        end
    endtask

    logic [3:0] seen;
    logic [9:0] ra;
    logic [3:0] rs;
    int         sel;
    int         restart2;

    initial begin
        vecs[0]  = '{10'h30e, 4'd0,  1'b0, 15, 4'b1111};
        vecs[1]  = '{10'h30f, 4'd0,  1'b1, 15, 4'b1111};
        vecs[2]  = '{10'h048, 4'd0,  1'b0, 15, 4'b0000};
        vecs[3]  = '{10'h320, 4'd0,  1'b1, 15, 4'b0000};
        vecs[4]  = '{10'h30c, 4'd2,  1'b0, 15, 4'b0000};
        vecs[5]  = '{10'h32e, 4'd2,  1'b1, 12, 4'b1111};
        vecs[6]  = '{10'h30d, 4'd0,  1'b1, 12, 4'b0000};
        vecs[7]  = '{10'h30c, 4'd0,  1'b1, 8,  4'b1010};
        vecs[8]  = '{10'h30e, 4'd0,  1'b0, 5,  4'b1101};
        vecs[9]  = '{10'h20e, 4'd0,  1'b0, 15, 4'b0000};
        vecs[10] = '{10'h3fe, 4'd15, 1'b1, 20, 4'b1111};

        rstl    = 1'b0;
        address = 10'h000;
        sp      = 4'd0;
        asl     = 1'b1;
        dsl     = 1'b1;
        rdwl    = 1'b1;

        // Reset state and power-on W5300 reset pulse length.
        repeat (3) tick();
        chk("reset outputs", {dsmcl, dtackl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl},
            8'b1110_1110);
        rstl      = 1'b1;
        rst_start = edge_n;
        repeat (RC - 1) tick();
        chk("wizrstl low at 255", 8'(wizrstl), 8'd0);
        tick();
        chk("wizrstl high at 256", 8'(wizrstl), 8'd1);

        // Decode / response table.
        for (int i = 0; i < 11; i++) begin
            run_cycle(vecs[i].addr, vecs[i].slot, vecs[i].rd, vecs[i].hold, seen);
            chk($sformatf("vec %0d seen", i), 8'(seen), 8'(vecs[i].exp_seen));
        end

        // Explicit W5300 write latencies.
        address = 10'h30e;
        sp      = 4'd0;
        rdwl    = 1'b0;
        asl     = 1'b0;
        #1;
        chk("wr dsmcl with asl", 8'(dsmcl), 8'd0);
        dsl = 1'b0;
        tick();
        tick();
        chk("wr cs not yet", 8'({wizcsl, wizwrl}), 8'b11);
        tick();
        chk("wr strobes at 3", 8'({wizcsl, wizwrl, dbenl, dbdir}), 8'b0000);
        repeat (SC - 1) tick();
        chk("wr no dtack yet", 8'({dtackl, wizwrl}), 8'b10);
        tick();
        chk("wr dtack, wr released", 8'({dtackl, wizwrl, wizcsl}), 8'b010);
        asl = 1'b1;
        dsl = 1'b1;
        tick();
        tick();
        chk("wr held in sync", 8'({dtackl, wizcsl, dbenl}), 8'b000);
        tick();
        chk("wr end released", 8'({dtackl, wizcsl, dbenl, wizwrl}), 8'b1111);
        repeat (2) tick();

        // Random bus cycles against the timeline model.
        for (int i = 0; i < 40; i++) begin
            rs  = 4'($urandom_range(0, 15));
            sel = int'($urandom_range(0, 9));
            if (sel < 5)      ra = {2'b11, rs, 3'b111, 1'($urandom_range(0, 1))};
            else if (sel < 7) ra = {2'b11, rs, 4'hC};
            else              ra = 10'($urandom_range(0, 1023));
            run_cycle(ra, rs, 1'($urandom_range(0, 1)), int'($urandom_range(2, 20)), seen);
        end

        // Control write, then a second one mid-pulse restarts the count.
        wait_chk(RC + 2);
        run_cycle(10'h30c, 4'd0, 1'b0, 6, seen);
        chk("ctrl wr pulse low", 8'({wizrstl, wizcsl, wizwrl, dbenl}), 8'b0111);
        wait_chk(90);
        run_cycle(10'h30c, 4'd0, 1'b0, 6, seen);
        restart2 = rst_start;
        wait_chk(restart2 + RC - 1 - edge_n);
        chk("restarted pulse low at 255", 8'(wizrstl), 8'd0);
        tick();
        chk("restarted pulse high at 256", 8'(wizrstl), 8'd1);

        // rstl asserted in the middle of a read cycle.
        address = 10'h30f;
        rdwl    = 1'b1;
        asl     = 1'b0;
        dsl     = 1'b0;
        repeat (6) tick();
        chk("mid read active", 8'({wizcsl, wizrdl, dbenl, dbdir}), 8'b0001);
        rstl = 1'b0;
        #1;
        chk("async reset outputs",
            {dsmcl, dtackl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl}, 8'b1110_1110);
        asl = 1'b1;
        dsl = 1'b1;
        tick();
        tick();
        rstl      = 1'b1;
        rst_start = edge_n;
        wait_chk(RC + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qe_control.md
# qe_control

Bus-cycle controller bridging the Sinclair QL (68008) expansion bus to a WIZnet W5300 Ethernet controller on a slot-addressed expansion card. Decodes the card's 16 KB slot and sub-windows, generates W5300 chip-select and read/write strobes, and drives the data-buffer and DSMCL/DTACKL handshakes. Also owns the W5300 hardware reset line.

## Interface
Parameters:
- STROBE_CYCLES, 7: clk cycles W5300 strobes are held before DTACKL (70 ns at 100 MHz).
- RST_CYCLES, 256: length of the W5300 reset pulse in clk cycles.

Ports:
- clk  in  1  system clock (100 MHz nominal).
- rstl  in  1  reset; asynchronous, active-low.
- address  in  10  QL A19..A10.
- sp  in  4  slot-position switches; selects the card's 16 KB slot.
- asl  in  1  68008 address strobe, active-low.
- dsl  in  1  68008 data strobe, active-low.
- rdwl  in  1  1 = read, 0 = write.
- dtackl  out  1  data-transfer acknowledge, active-low.
- dsmcl  out  1  tells the QL the card decodes this address, active-low.
- dbenl  out  1  data-buffer enable, active-low.
- dbdir  out  1  buffer direction: 1 = card→QL, 0 = QL→card.
- wizcsl, wizrdl, wizwrl  out  1 each  W5300 chip select, read, write strobes, active-low.
- wizrstl  out  1  W5300 reset, active-low.

## Operation
- Card select: address[9:8]==2'b11 and address[7:4]==sp.
- W5300 window: card select and address[3:1]==3'b111 (offsets 0xE, 0xF).
- Control window: card select and address[3:0]==4'hC.
- Other offsets: no response (dsmcl, dtackl, dbenl high).
- dsmcl: combinational; low while asl low and W5300 or control window decoded.
- asl, dsl, rdwl pass through two-flop synchronisers; FSM uses synchronised copies; decode uses live address qualified by synchronised asl.
- FSM states: IDLE, STROBE, ACK, WAIT_END.
  - IDLE → STROBE: W5300 window and dsl low. wizcsl low; wizrdl low (read) or wizwrl low (write); dbenl low; dbdir = rdwl; counter cleared.
  - STROBE → ACK: counter reaches STROBE_CYCLES-1. Write: wizwrl released. Read: wizrdl held. dtackl driven low.
  - ACK → WAIT_END: immediately; dtackl stays low.
  - WAIT_END → IDLE: asl and dsl both high. All strobes, dbenl, dtackl released.
- Aborted cycle: asl high in STROBE → IDLE, all outputs released, no dtackl.
- Control window write: IDLE → ACK directly, no W5300 strobes, dbenl high; W5300 reset pulse (re)starts.
- Control window read: acknowledged the same way, dbenl high, no side effect.
- Reset pulse: wizrstl low for RST_CYCLES clocks, then high. Rewrite during a pulse restarts the count.
- dbdir is 0 outside active read cycles.

## Timing
- Reset values: dtackl, dbenl, wizcsl, wizrdl, wizwrl = 1; dbdir = 0; wizrstl = 0; FSM = IDLE.
- On rstl release, wizrstl stays low for RST_CYCLES clocks.
- rstl low mid-cycle: immediate IDLE and all bus outputs inactive.
- dsl→strobe latency: 2 sync cycles + 1 = 3 clocks.
- Strobe→dtackl latency: STROBE_CYCLES clocks.
- End of cycle: strobes/dtackl released 3 clocks after last strobe rises.
- wizcsl asserted no later than wizrdl/wizwrl; released no earlier.
- Back-to-back cycles: no new cycle starts until IDLE re-entered.

## Structure
- Package qe_pkg: FSM state enum; window offset constants (W5300 = 3'b111 on A13..A11, CTRL = 4'hC); slot prefix 2'b11.
- One sub-module: qe_sync (two-flop synchroniser, async active-low reset, parametric width), instantiated for asl/dsl/rdwl.

## Test plan
- Reset: rstl low → all strobes/dtackl/dbenl = 1, wizrstl = 0; after release wizrstl rises after exactly 256 clocks.
- W5300 write, sp=0, address=0x30e, rdwl=0: dsmcl low with asl; wizcsl/wizwrl low 3 clocks after dsl; dtackl low 7 clocks later; wizwrl high at dtackl; all released after asl/dsl high.
- W5300 read, address=0x30f, rdwl=1: wizrdl and dbenl low, dbdir=1, held until dsl rises; dtackl after 7 strobe clocks.
- Non-decoded addresses 0x048, 0x320 (sp=0), 0x30c with sp=2: dsmcl, dtackl, wizcsl stay high.
- Control write address=0x30c, rdwl=0: dtackl low, no W5300 strobes, wizrstl low 256 clocks; second write mid-pulse restarts count.
- Abort: asl high two clocks into STROBE → strobes released, dtackl never asserted.
